// File: rtl/cache_writeback_ctrl.sv
// Miss/eviction controller for the direct-mapped cache.
// Writes back dirty victims, fetches the new line and maintains the dirty store.
module cache_writeback_ctrl #(
    parameter int NUM_SETS = 8,
    parameter int INDEX_W  = 3,
    parameter int TAG_W    = 24,
    parameter int LINE_W   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               miss_req,
    input  logic [INDEX_W-1:0] miss_index,
    input  logic [TAG_W-1:0]   miss_tag,
    input  logic [TAG_W-1:0]   victim_tag,
    input  logic               victim_dirty,
    input  logic [LINE_W-1:0]  victim_data,
    input  logic               wr_hit,
    input  logic [INDEX_W-1:0] wr_index,
    output logic               busy,
    output logic               miss_done,
    output logic [INDEX_W-1:0] dirty_index,
    output logic               dirty_in,
    output logic               dirty_load,
    output logic               fill_load,
    output logic [LINE_W-1:0]  fill_data,
    output logic [TAG_W-1:0]   fill_tag,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    output logic [LINE_W-1:0]  pmem_wdata,
    input  logic               pmem_resp,
    input  logic [LINE_W-1:0]  pmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [INDEX_W:0] SETS = NUM_SETS[INDEX_W:0];

    state_t state;
    state_t state_nx;

    logic [INDEX_W-1:0] index_l;
    logic [TAG_W-1:0]   miss_tag_l;
    logic [TAG_W-1:0]   victim_tag_l;
    logic [LINE_W-1:0]  victim_data_l;
    logic               dirty_l;

    logic               wr_ok;
    logic               accept;
    logic [31:0]        wb_addr;
    logic [31:0]        rd_addr;

    // A write hit to a set that does not exist is dropped.
    assign wr_ok   = wr_hit && ({1'b0, wr_index} < SETS);
    assign accept  = (state == S_IDLE) && miss_req;
    assign wb_addr = {victim_tag_l, index_l, 5'b0};
    assign rd_addr = {miss_tag_l, index_l, 5'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index_l       <= '0;
            miss_tag_l    <= '0;
            victim_tag_l  <= '0;
            victim_data_l <= '0;
            dirty_l       <= 1'b0;
        end else if (accept) begin
            index_l       <= miss_index;
            miss_tag_l    <= miss_tag;
            victim_tag_l  <= victim_tag;
            victim_data_l <= victim_data;
            dirty_l       <= victim_dirty;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (miss_req) begin
                    state_nx = victim_dirty ? S_WRITEBACK : S_FILL;
                end
            end
            S_WRITEBACK: begin
                if (pmem_resp) begin
                    state_nx = S_FILL;
                end
            end
            S_FILL: begin
                if (pmem_resp) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        miss_done    = 1'b0;
        dirty_index  = '0;
        dirty_in     = 1'b0;
        dirty_load   = 1'b0;
        fill_load    = 1'b0;
        fill_data    = '0;
        fill_tag     = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state)
            S_IDLE: begin
                if (wr_ok) begin
                    dirty_load  = 1'b1;
                    dirty_in    = 1'b1;
                    dirty_index = wr_index;
                end else begin
                    dirty_index = miss_index;
                end
            end
            S_WRITEBACK: begin
                busy         = 1'b1;
                pmem_write   = dirty_l;
                pmem_address = wb_addr;
                pmem_wdata   = victim_data_l;
            end
            S_FILL: begin
                busy         = 1'b1;
                pmem_read    = 1'b1;
                pmem_address = rd_addr;
                dirty_index  = index_l;
                // Fill and dirty clear happen only in the response cycle.
                if (pmem_resp) begin
                    fill_load  = 1'b1;
                    fill_data  = pmem_rdata;
                    fill_tag   = miss_tag_l;
                    dirty_load = 1'b1;
                    dirty_in   = 1'b0;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                miss_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
